aes_i2c_master: RTL and testbench
=================================

AES_I2C_MASTER -- requirements
Module: aes_i2c_master

Interface
REQ-001 SHALL have parameter QTR, default 5, meaning system clocks per quarter SCL bit period; legal values are QTR >= 2.
REQ-002 SHALL have parameter SLV_ADDR, default 7'b1011001, meaning the 7-bit target address (write byte 0xB2, read byte 0xB3).
REQ-003 Port clk, input, 1 bit: the single system clock; all logic uses its rising edge.
REQ-004 Port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start_write, input, 1 bit: one-cycle request to write key_in to the target.
REQ-006 Port start_read, input, 1 bit: one-cycle request to read one 128-bit ciphertext block.
REQ-007 Port key_in, input, 128 bits: key, captured on an accepted start_write.
REQ-008 Port sda_in, input, 1 bit: resolved SDA bus level.
REQ-009 Port scl_out, output, 1 bit: SCL drive; 1 = release, 0 = pull low.
REQ-010 Port sda_out, output, 1 bit: SDA drive; 1 = release, 0 = pull low.
REQ-011 Port busy, output, 1 bit: high from request acceptance until done.
REQ-012 Port done, output, 1 bit: one-cycle pulse at transaction end.
REQ-013 Port nack_err, output, 1 bit: valid with done; 1 = transaction aborted on a NACK.
REQ-014 Port data_out, output, 128 bits: received block, valid from done until the next accepted start_read.

Function
REQ-015 SHALL accept a request only in IDLE; requests while busy SHALL be ignored; if start_write and start_read are both high in the same cycle, write SHALL win.
REQ-016 Bit cell SHALL be 4 quarters of QTR clocks: Q0 SCL low with SDA updated at Q0 entry, Q1 SCL low, Q2 and Q3 SCL high; sda_in SHALL be sampled on the last clock of Q2.
REQ-017 START SHALL drive SDA 1 to 0 while SCL = 1 (one quarter each state), then SCL 0; STOP SHALL drive SDA 0 with SCL 0, raise SCL, then raise SDA after one quarter.
REQ-018 Bytes SHALL be shifted MSB first; the key SHALL be sent key_in[127:120] first; received bytes SHALL fill data_out[127:120] first.
REQ-019 The FSM SHALL have states IDLE, START, ADDR, ADDR_ACK, WBYTE, WACK, RBYTE, RACK, STOP and DONE.
REQ-020 On an address NACK (sda_in = 1 in ADDR_ACK), the block SHALL go to STOP, then DONE with nack_err = 1.
REQ-021 Write: key bytes 1-15 SHALL require ACK, and a NACK on any of them SHALL abort as in REQ-020; the ACK bit of byte 16 SHALL be ignored, because the target NACKs the last key byte.
REQ-022 Read: the master SHALL drive SDA = 0 (ACK) after bytes 1-15 and SDA = 1 (NACK) after byte 16, then STOP.
REQ-023 During RBYTE the master SHALL hold sda_out = 1.
REQ-024 A 4-bit byte counter SHALL count 0-15 and wrap to 0 at transaction start; the 3-bit bit counter SHALL count 7 down to 0.
REQ-025 data_out SHALL update only on a successful read, as one 128-bit load at DONE; on an error or a write it SHALL hold its old value.
REQ-026 done SHALL pulse for exactly one cycle, the cycle DONE is entered; busy SHALL fall in that same cycle and the FSM SHALL then return to IDLE.
REQ-027 Clock stretching and arbitration are not supported; the SCL level SHALL NOT be read.

Reset
REQ-028 On n_rst = 0, all state SHALL clear asynchronously: scl_out = 1, sda_out = 1, busy = 0, done = 0, nack_err = 0, data_out = 0, FSM = IDLE, all counters = 0.
REQ-029 A reset mid-transaction SHALL release both lines immediately, with no STOP generated; after reset the first request SHALL begin with a fresh START.

Structure
REQ-030 Package aes_i2c_pkg SHALL hold the state enum, SLV_ADDR default, KEY_BYTES = 16 and the R/W bit constants.
REQ-031 Quarter/phase timing SHALL live in sub-module i2c_bit_timer, with inputs clk, n_rst, run and outputs phase[1:0], phase_end, sample; the FSM SHALL advance only on phase_end.

Verification
REQ-032 start_write with key_in = 0x746869736973616b6579666561726d65 and an ACKing slave model, the 16th byte NACKed -> bytes B2, 74, 68, ... 65 on the bus; done with nack_err = 0; 1+16 ACK slots.
REQ-033 start_read, slave ACKs B3 and returns 0x2ce2c3408ce0aca66e86b19ce60c0abc -> data_out equals that value at done; master ACKs 15 times then NACKs; STOP seen; nack_err = 0.
REQ-034 start_read, slave NACKs address (empty FIFO) -> STOP right after the address ACK slot; done with nack_err = 1; data_out unchanged.
REQ-035 start_write and start_read in the same cycle, plus start_read pulsed mid-write -> only the write runs (first byte B2); no second transaction starts.
REQ-036 n_rst asserted during key byte 7 -> scl_out = sda_out = 1 in the same cycle; a new start_write completes normally with the START condition and timing at QTR = 5 (SCL high 10 clocks, low 10 clocks).

Source files
------------

// File: rtl/aes_i2c_pkg.sv
// aes_i2c_pkg: shared FSM states and bus constants for the AES key/ciphertext I2C master
package aes_i2c_pkg;
   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WBYTE, WACK, RBYTE, RACK, STOP, DONE
   } state_e;
   localparam logic [6:0] SLV_ADDR_DEF = 7'b1011001;
   localparam int         KEY_BYTES    = 16;
   localparam logic       RW_WRITE     = 1'b0;
   localparam logic       RW_READ      = 1'b1;
endpackage

// File: rtl/aes_i2c_master_bit_timer.sv
// i2c_bit_timer: splits a running bit cell into four quarters of QTR clocks
module i2c_bit_timer #(
   parameter int QTR = 5
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       run,
   output logic [1:0] phase,
   output logic       phase_end,
   output logic       sample
);
   localparam int CW = $clog2(QTR);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    phase_q, phase_d;
   logic          qend;
   // quarter counter and phase step; both held at zero while idle
   always_comb begin
      qend    = cnt_q == CW'(QTR - 1);
      cnt_d   = (!run || qend) ? '0 : cnt_q + CW'(1);
      phase_d = !run ? 2'd0 : phase_q + {1'b0, qend};
   end
   // timer state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q   <= '0;
         phase_q <= 2'd0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end
   assign phase     = phase_q;
   assign phase_end = run && qend && phase_q == 2'd3;
   assign sample    = run && qend && phase_q == 2'd2;
endmodule

// File: rtl/aes_i2c_master.sv
// aes_i2c_master: I2C master that writes a 128-bit AES key or reads one 128-bit ciphertext block
module aes_i2c_master
   import aes_i2c_pkg::*;
#(
   parameter int         QTR      = 5,
   parameter logic [6:0] SLV_ADDR = SLV_ADDR_DEF
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start_write,
   input  logic         start_read,
   input  logic [127:0] key_in,
   input  logic         sda_in,
   output logic         scl_out,
   output logic         sda_out,
   output logic         busy,
   output logic         done,
   output logic         nack_err,
   output logic [127:0] data_out
);
   localparam logic [3:0] LAST_BYTE = 4'(KEY_BYTES - 1);
   state_e       state_q, state_d;
   logic [2:0]   bit_q, bit_d;
   logic [3:0]   byte_q, byte_d;
   logic [7:0]   tx_q, tx_d;
   logic [127:0] key_q, key_d, rx_q, rx_d, data_q, data_d;
   logic         rw_q, rw_d, ack_q, ack_d, nack_q, nack_d;
   logic         scl_q, scl_d, sda_q, sda_d;
   logic         run, phase_end, sample;
   logic [1:0]   phase;

   assign run = !(state_q == IDLE || state_q == DONE);

   i2c_bit_timer #(.QTR(QTR)) u_timer (
      .clk       (clk),
      .n_rst     (n_rst),
      .run       (run),
      .phase     (phase),
      .phase_end (phase_end),
      .sample    (sample)
   );

   // next-state logic: FSM moves only at bit-cell ends, except accept and DONE->IDLE
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      key_d   = key_q;
      rx_d    = rx_q;
      data_d  = data_q;
      rw_d    = rw_q;
      nack_d  = nack_q;
      ack_d   = sample ? sda_in : ack_q;
      if (state_q == IDLE && (start_write || start_read)) begin
         state_d = START;
         rw_d    = start_write ? RW_WRITE : RW_READ;
         tx_d    = {SLV_ADDR, start_write ? RW_WRITE : RW_READ};
         key_d   = start_write ? key_in : key_q;
         bit_d   = 3'd7;
         byte_d  = 4'd0;
         nack_d  = 1'b0;
      end
      if (state_q == RBYTE && sample) rx_d = {rx_q[126:0], sda_in};
      if (state_q == DONE) state_d = IDLE;
      if (phase_end) begin
         unique case (state_q)
            START: state_d = ADDR;
            ADDR, WBYTE, RBYTE: begin
               bit_d = bit_q - 3'd1;
               tx_d  = {tx_q[6:0], 1'b0};
               if (bit_q == 3'd0)
                  state_d = state_q == ADDR ? ADDR_ACK : state_q == WBYTE ? WACK : RACK;
            end
            ADDR_ACK: begin
               if (ack_q) begin
                  state_d = STOP;
                  nack_d  = 1'b1;
               end else if (rw_q == RW_READ) begin
                  state_d = RBYTE;
               end else begin
                  state_d = WBYTE;
                  tx_d    = key_q[127:120];
                  key_d   = {key_q[119:0], 8'h00};
               end
            end
            WACK: begin
               byte_d = byte_q + 4'd1;
               if (byte_q == LAST_BYTE) begin
                  state_d = STOP;
               end else if (ack_q) begin
                  state_d = STOP;
                  nack_d  = 1'b1;
               end else begin
                  state_d = WBYTE;
                  tx_d    = key_q[127:120];
                  key_d   = {key_q[119:0], 8'h00};
               end
            end
            RACK: begin
               byte_d  = byte_q + 4'd1;
               state_d = byte_q == LAST_BYTE ? STOP : RBYTE;
            end
            STOP: begin
               state_d = DONE;
               if (rw_q == RW_READ && !nack_q) data_d = rx_q;
            end
            default: ;
         endcase
      end
   end

   // line drive decode; registered so SCL/SDA never glitch
   always_comb begin
      scl_d = !run ? 1'b1 : state_q == START ? !phase[1] : phase[1];
      sda_d = !run                                 ? 1'b1 :
              state_q == START                     ? phase == 2'd0 :
              state_q == STOP                      ? phase == 2'd3 :
              (state_q == ADDR || state_q == WBYTE) ? tx_q[7] :
              state_q == RACK                      ? byte_q == LAST_BYTE : 1'b1;
   end

   // state registers; reset releases both lines at once
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         bit_q   <= 3'd0;
         byte_q  <= 4'd0;
         tx_q    <= 8'h00;
         key_q   <= '0;
         rx_q    <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         key_q   <= key_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         rw_q    <= rw_d;
         ack_q   <= ack_d;
         nack_q  <= nack_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
      end
   end

   assign scl_out  = scl_q;
   assign sda_out  = sda_q;
   assign busy     = run;
   assign done     = state_q == DONE;
   assign nack_err = nack_q;
   assign data_out = data_q;
endmodule

// File: tb/tb_aes_i2c_master.sv
// tb_aes_i2c_master: bus-level slave model and transcript checks for aes_i2c_master
module tb_aes_i2c_master;
   localparam int QTR = 5;
   logic         clk = 1'b0, n_rst = 1'b1, start_write = 1'b0, start_read = 1'b0;
   logic [127:0] key_in = '0;
   logic         sda_in, scl_out, sda_out, busy, done, nack_err;
   logic [127:0] data_out;
   logic         slv_sda = 1'b1;
   logic         addr_ack = 1'b1;
   int           nack_byte = 16;
   logic [127:0] slv_data = '0;
   logic         rb[$];
   int           rt[$], ft[$];
   int           n_start = 0, n_stop = 0, t_start = 0, cyc = 0;
   logic         pscl = 1'b1, psda = 1'b1;
   int           checks = 0, fails = 0;

   assign sda_in = sda_out & slv_sda;

   aes_i2c_master #(.QTR(QTR)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start_write (start_write),
      .start_read  (start_read),
      .key_in      (key_in),
      .sda_in      (sda_in),
      .scl_out     (scl_out),
      .sda_out     (sda_out),
      .busy        (busy),
      .done        (done),
      .nack_err    (nack_err),
      .data_out    (data_out)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // what the slave drives for the bit whose SCL rise will be number k after START
   function automatic logic slave_bit(input int k);
      int f, p;
      f = k / 9;
      p = k % 9;
      if (f == 0) return p == 8 ? !addr_ack : 1'b1;
      if (f > 16) return 1'b1;
      if (rb[7] == 1'b0) return p == 8 ? (f == nack_byte) : 1'b1;
      return p == 8 ? 1'b1 : slv_data[127 - 8 * (f - 1) - p];
   endfunction

   // bus monitor and slave: logs SDA at every SCL rise, updates slave drive on SCL fall
   initial forever begin
      @(negedge clk);
      cyc++;
      if (pscl && scl_out && psda && !sda_in) begin
         n_start++;
         t_start = cyc;
         rb.delete();
         rt.delete();
         ft.delete();
      end
      if (pscl && scl_out && !psda && sda_in) n_stop++;
      if (!pscl && scl_out) begin
         rb.push_back(sda_in);
         rt.push_back(cyc);
      end
      if (pscl && !scl_out) begin
         ft.push_back(cyc);
         slv_sda = slave_bit(rb.size());
      end
      if (!n_rst) slv_sda = 1'b1;
      pscl = scl_out;
      psda = sda_out & slv_sda;
   end

   task automatic pulse(input logic w, input logic r, input logic [127:0] k);
      start_write = w;
      start_read  = r;
      key_in      = k;
      @(negedge clk);
      start_write = 1'b0;
      start_read  = 1'b0;
   endtask

   task automatic finish_txn(input string nm, input logic exp_nack);
      int n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         fails++;
         $display("FAIL %s: done not seen within 5000 cycles", nm);
         return;
      end
      checks++;
      if (nack_err !== exp_nack) begin
         fails++;
         $display("FAIL %s nack_err: got %b want %b", nm, nack_err, exp_nack);
      end
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL %s busy at done: got %b want 0", nm, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL %s done width: got %b one cycle later, want 0", nm, done);
      end
   endtask

   task automatic check_frames(input string nm, input logic [7:0] eb[$], input logic ea[$]);
      logic [7:0] b;
      checks++;
      if (rb.size() != 9 * eb.size() + 1) begin
         fails++;
         $display("FAIL %s frame count: got %0d SCL rises, want %0d", nm, rb.size(), 9 * eb.size() + 1);
         return;
      end
      for (int f = 0; f < eb.size(); f++) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) b = {b[6:0], rb[9 * f + i]};
         checks++;
         if (b !== eb[f] || rb[9 * f + 8] !== ea[f]) begin
            fails++;
            $display("FAIL %s frame %0d: got byte %h ack %b, want byte %h ack %b",
                     nm, f, b, rb[9 * f + 8], eb[f], ea[f]);
         end
      end
   endtask

   task automatic test_reset();
      #2 n_rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({scl_out, sda_out, busy, done, nack_err} !== 5'b11000) begin
         fails++;
         $display("FAIL reset outputs: got scl,sda,busy,done,nack=%b want 11000",
                  {scl_out, sda_out, busy, done, nack_err});
      end
      checks++;
      if (data_out !== 128'h0) begin
         fails++;
         $display("FAIL reset data_out: got %h want 0", data_out);
      end
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write(input string nm, input logic [127:0] key, input int nb, input bit collide);
      logic [7:0]   eb[$];
      logic         ea[$];
      int           ns, nst;
      logic [127:0] dprev;
      nack_byte = nb;
      ns        = n_stop;
      nst       = n_start;
      dprev     = data_out;
      eb.push_back(8'hB2);
      ea.push_back(1'b0);
      for (int i = 1; i <= nb; i++) begin
         eb.push_back(key[127 - 8 * (i - 1) -: 8]);
         ea.push_back(i == nb);
      end
      pulse(1'b1, collide, key);
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL %s accept: busy=%b want 1", nm, busy);
      end
      if (collide) begin
         repeat (100) @(negedge clk);
         pulse(1'b0, 1'b1, '0);
      end
      finish_txn(nm, nb < 16);
      check_frames(nm, eb, ea);
      checks++;
      if (n_stop !== ns + 1) begin
         fails++;
         $display("FAIL %s STOP count: got %0d want %0d", nm, n_stop, ns + 1);
      end
      checks++;
      if (data_out !== dprev) begin
         fails++;
         $display("FAIL %s data_out changed: got %h want %h", nm, data_out, dprev);
      end
      if (collide) begin
         repeat (300) @(negedge clk);
         checks++;
         if (busy !== 1'b0 || n_start !== nst + 1) begin
            fails++;
            $display("FAIL %s extra transaction: busy=%b starts=%0d want busy=0 starts=%0d",
                     nm, busy, n_start, nst + 1);
         end
      end
      nack_byte = 16;
   endtask

   task automatic test_read(input string nm, input logic [127:0] blk, input logic aack);
      logic [7:0]   eb[$];
      logic         ea[$];
      int           ns;
      logic [127:0] dprev;
      addr_ack = aack;
      slv_data = blk;
      dprev    = data_out;
      ns       = n_stop;
      eb.push_back(8'hB3);
      ea.push_back(!aack);
      if (aack) for (int i = 0; i < 16; i++) begin
         eb.push_back(blk[127 - 8 * i -: 8]);
         ea.push_back(i == 15);
      end
      pulse(1'b0, 1'b1, '0);
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL %s accept: busy=%b want 1", nm, busy);
      end
      finish_txn(nm, !aack);
      checks++;
      if (data_out !== (aack ? blk : dprev)) begin
         fails++;
         $display("FAIL %s data_out: got %h want %h", nm, data_out, aack ? blk : dprev);
      end
      check_frames(nm, eb, ea);
      checks++;
      if (n_stop !== ns + 1) begin
         fails++;
         $display("FAIL %s STOP count: got %0d want %0d", nm, n_stop, ns + 1);
      end
      addr_ack = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n = 0, ns, nst;
      pulse(1'b1, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()});
      while (!(rb.size() >= 66 && !scl_out) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 5000) begin
         fails++;
         $display("FAIL reset_mid: key byte 7 not reached within 5000 cycles");
      end
      ns    = n_stop;
      n_rst = 1'b0;
      #1;
      checks++;
      if ({scl_out, sda_out, busy, done, nack_err} !== 5'b11000) begin
         fails++;
         $display("FAIL reset_mid outputs: got scl,sda,busy,done,nack=%b want 11000",
                  {scl_out, sda_out, busy, done, nack_err});
      end
      checks++;
      if (data_out !== 128'h0) begin
         fails++;
         $display("FAIL reset_mid data_out: got %h want 0", data_out);
      end
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (n_stop !== ns) begin
         fails++;
         $display("FAIL reset_mid STOP on reset: got %0d STOPs want %0d", n_stop, ns);
      end
      nst = n_start;
      test_write("write after reset", {$urandom(), $urandom(), $urandom(), $urandom()}, 16, 1'b0);
      checks++;
      if (n_start !== nst + 1 || ft.size() == 0 || ft[0] - t_start !== QTR) begin
         fails++;
         $display("FAIL reset_mid START: starts=%0d SDA-to-SCL fall=%0d want starts=%0d gap=%0d",
                  n_start, ft.size() ? ft[0] - t_start : -1, nst + 1, QTR);
      end
      for (int i = 0; i + 1 < rt.size() && i + 1 < ft.size(); i++) begin
         checks++;
         if (ft[i + 1] - rt[i] !== 2 * QTR) begin
            fails++;
            $display("FAIL scl high %0d: got %0d clocks want %0d", i, ft[i + 1] - rt[i], 2 * QTR);
         end
      end
      for (int i = 1; i < rt.size() && i < ft.size(); i++) begin
         checks++;
         if (rt[i] - ft[i] !== 2 * QTR) begin
            fails++;
            $display("FAIL scl low %0d: got %0d clocks want %0d", i, rt[i] - ft[i], 2 * QTR);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write("spec key write", 128'h746869736973616b6579666561726d65, 16, 1'b0);
      test_read("spec read", 128'h2ce2c3408ce0aca66e86b19ce60c0abc, 1'b1);
      test_read("address nack", {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
      test_write("random key write", {$urandom(), $urandom(), $urandom(), $urandom()}, 16, 1'b0);
      test_write("key byte nack", {$urandom(), $urandom(), $urandom(), $urandom()},
                 int'($urandom_range(1, 15)), 1'b0);
      test_read("random read", {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      test_write("write/read collision", {$urandom(), $urandom(), $urandom(), $urandom()}, 16, 1'b1);
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
